// File: rtl/ex_muldiv_stage.sv
// EX stage: same-cycle logic/shift results for ID forwarding, plus an optional
// 32-step restoring divider for DIV/DIVU that is compiled in only when EX_DIV_EN is defined.
module ex_muldiv_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [2:0]  alusel_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_data_i,
  input  logic [31:0] reg2_data_i,
  input  logic [4:0]  waddr_i,
  input  logic        wreg_i,
  output logic        wreg_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  localparam int unsigned DW = 32;

  localparam logic [2:0] ALU_RES_NOP   = 3'b000;
  localparam logic [2:0] ALU_RES_LOGIC = 3'b001;
  localparam logic [2:0] ALU_RES_SHIFT = 3'b010;
  localparam logic [2:0] ALU_RES_ARITH = 3'b100;

  localparam logic [7:0] OP_AND = 8'b0010_0100;
  localparam logic [7:0] OP_OR  = 8'b0010_0101;
  localparam logic [7:0] OP_XOR = 8'b0010_0110;
  localparam logic [7:0] OP_NOR = 8'b0010_0111;
  localparam logic [7:0] OP_SLL = 8'b0111_1100;
  localparam logic [7:0] OP_SRL = 8'b0000_0010;
  localparam logic [7:0] OP_SRA = 8'b0000_0011;

  logic [DW-1:0] result_c;
  logic [4:0]    shamt_c;

  // Single-cycle logic/shift datapath feeding the forwarding path
  always_comb begin
    result_c = '0;
    shamt_c  = reg2_data_i[4:0];
    case (alusel_i)
      ALU_RES_LOGIC: begin
        case (aluop_i)
          OP_AND:  result_c = reg1_data_i & reg2_data_i;
          OP_OR:   result_c = reg1_data_i | reg2_data_i;
          OP_XOR:  result_c = reg1_data_i ^ reg2_data_i;
          OP_NOR:  result_c = ~(reg1_data_i | reg2_data_i);
          default: result_c = '0;
        endcase
      end
      ALU_RES_SHIFT: begin
        case (aluop_i)
          OP_SLL:  result_c = reg1_data_i << shamt_c;
          OP_SRL:  result_c = reg1_data_i >> shamt_c;
          OP_SRA:  result_c = DW'($signed(reg1_data_i) >>> shamt_c);
          default: result_c = '0;
        endcase
      end
      ALU_RES_NOP, ALU_RES_ARITH: result_c = '0;
      default:                    result_c = '0;
    endcase
  end

  assign wreg_o  = rst & wreg_i;
  assign waddr_o = rst ? waddr_i : '0;
  assign wdata_o = rst ? result_c : '0;

`ifdef EX_DIV_EN
  localparam int unsigned DIV_CYCLES = 32;
  localparam int unsigned CNT_W      = $clog2(DIV_CYCLES);

  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ZERO,
    ST_ON,
    ST_END
  } div_state_e;

  div_state_e       state_q;
  logic [2*DW-1:0]  sh_q;
  logic [DW-1:0]    dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_quot_q;
  logic             neg_rem_q;
  logic             whilo_q;
  logic [DW-1:0]    hi_q;
  logic [DW-1:0]    lo_q;

  logic             div_op_c;
  logic             is_signed_c;
  logic [DW-1:0]    dvd_abs_c;
  logic [DW-1:0]    dvs_abs_c;
  logic [2*DW:0]    shift_c;
  logic [DW:0]      trial_c;
  logic [2*DW-1:0]  step_c;
  logic [DW-1:0]    quot_c;
  logic [DW-1:0]    rem_c;

  // Operand conditioning and one restoring step on the 65-bit {rem, quot} shifter
  always_comb begin
    div_op_c    = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    is_signed_c = (aluop_i == OP_DIV);
    dvd_abs_c   = (is_signed_c && reg1_data_i[DW-1]) ? DW'(-reg1_data_i) : reg1_data_i;
    dvs_abs_c   = (is_signed_c && reg2_data_i[DW-1]) ? DW'(-reg2_data_i) : reg2_data_i;
    shift_c     = {sh_q, 1'b0};
    trial_c     = shift_c[2*DW:DW] - {1'b0, dvs_q};
    if (trial_c[DW]) begin
      step_c = shift_c[2*DW-1:0];
    end else begin
      step_c = {trial_c[DW-1:0], shift_c[DW-1:1], 1'b1};
    end
    quot_c = neg_quot_q ? DW'(-step_c[DW-1:0])    : step_c[DW-1:0];
    rem_c  = neg_rem_q  ? DW'(-step_c[2*DW-1:DW]) : step_c[2*DW-1:DW];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      sh_q       <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      whilo_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      whilo_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      case (state_q)
        ST_IDLE: begin
          if (div_op_c && !flush_i) begin
            if (reg2_data_i == '0) begin
              state_q <= ST_ZERO;
            end else begin
              state_q    <= ST_ON;
              sh_q       <= {{DW{1'b0}}, dvd_abs_c};
              dvs_q      <= dvs_abs_c;
              neg_quot_q <= is_signed_c && (reg1_data_i[DW-1] ^ reg2_data_i[DW-1]);
              neg_rem_q  <= is_signed_c && reg1_data_i[DW-1];
              cnt_q      <= '0;
            end
          end
        end
        ST_ZERO: begin
          if (flush_i) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_END;
            whilo_q <= 1'b1;
          end
        end
        ST_ON: begin
          if (flush_i) begin
            state_q <= ST_IDLE;
          end else begin
            sh_q  <= step_c;
            cnt_q <= cnt_q + CNT_W'(1);
            // Final step: load fixed-up results so they are visible throughout END
            if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
              state_q <= ST_END;
              whilo_q <= 1'b1;
              hi_q    <= rem_c;
              lo_q    <= quot_c;
            end
          end
        end
        ST_END:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stallreq_o = rst && !flush_i &&
                      (((state_q == ST_IDLE) && div_op_c) ||
                       (state_q == ST_ZERO) || (state_q == ST_ON));
  assign whilo_o = whilo_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
`else
  logic unused_c;
  assign unused_c   = ^{flush_i, clk};
  assign stallreq_o = 1'b0;
  assign whilo_o    = 1'b0;
  assign hi_o       = '0;
  assign lo_o       = '0;
`endif

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Scoreboard bench for ex_muldiv_stage; expectations adapt to whether EX_DIV_EN is defined.
module tb_ex_muldiv_stage;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  typedef struct packed {
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        stall;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic [2:0]  alusel_i;
  logic [7:0]  aluop_i;
  logic [31:0] reg1_data_i;
  logic [31:0] reg2_data_i;
  logic [4:0]  waddr_i;
  logic        wreg_i;
  logic        wreg_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mon_cyc  = 0;

  ex_muldiv_stage dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .alusel_i    (alusel_i),
    .aluop_i     (aluop_i),
    .reg1_data_i (reg1_data_i),
    .reg2_data_i (reg2_data_i),
    .waddr_i     (waddr_i),
    .wreg_i      (wreg_i),
    .wreg_o      (wreg_o),
    .waddr_o     (waddr_o),
    .wdata_o     (wdata_o),
    .whilo_o     (whilo_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .stallreq_o  (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: result of a logic/shift instruction
  function automatic logic [31:0] ref_wdata(input logic [2:0] sel, input logic [7:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    if (sel == SEL_LOGIC) begin
      if (op == OP_AND) return a & b;
      if (op == OP_OR)  return a | b;
      if (op == OP_XOR) return a ^ b;
      if (op == OP_NOR) return ~(a | b);
    end else if (sel == SEL_SHIFT) begin
      if (op == OP_SLL) return a << sh;
      if (op == OP_SRL) return a >> sh;
      if (op == OP_SRA) return 32'($signed(a) >>> sh);
    end
    return 32'h0;
  endfunction

  // Reference: quotient/remainder with truncating signed semantics, 0/0 on divide by zero
  function automatic void ref_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    if (b == 32'h0) begin
      q = 32'h0;
      r = 32'h0;
    end else if (op == OP_DIVU) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
  endfunction

  function automatic exp_t base_exp(input logic r, input logic [2:0] sel, input logic [7:0] op,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic [4:0] wa, input logic wr);
    exp_t e;
    e = '0;
    if (r) begin
      e.wreg  = wr;
      e.waddr = wa;
      e.wdata = ref_wdata(sel, op, a, b);
    end
    return e;
  endfunction

  task automatic step(input logic r, input logic fl, input logic [2:0] sel, input logic [7:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa,
                      input logic wr, input exp_t e);
    @(posedge clk);
    #1;
    rst         = r;
    flush_i     = fl;
    alusel_i    = sel;
    aluop_i     = op;
    reg1_data_i = a;
    reg2_data_i = b;
    waddr_i     = wa;
    wreg_i      = wr;
    exp_q.push_back(e);
  endtask

  // Issue one instruction, holding it for as long as the model says the stage stalls.
  // flush_at / rst_at give the cycle (0 = first) in which flush or reset hits; -1 = never.
  task automatic issue(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wa, input logic wr,
                       input int flush_at, input int rst_at);
    exp_t        e;
    int          n;
    logic [31:0] q;
    logic [31:0] r;
    e = base_exp(1'b1, sel, op, a, b, wa, wr);
`ifdef EX_DIV_EN
    if (op == OP_DIV || op == OP_DIVU) begin
      ref_div(op, a, b, q, r);
      n = (b == 32'h0) ? 2 : 33;
      for (int k = 0; k <= n; k++) begin
        if (k == rst_at) begin
          step(1'b0, 1'b0, sel, op, a, b, wa, wr, base_exp(1'b0, sel, op, a, b, wa, wr));
          return;
        end
        e.stall = (k < n) && (k != flush_at);
        e.whilo = (k == n);
        e.hi    = (k == n) ? r : 32'h0;
        e.lo    = (k == n) ? q : 32'h0;
        step(1'b1, k == flush_at, sel, op, a, b, wa, wr, e);
        if (k == flush_at) return;
      end
      return;
    end
`endif
    if (rst_at == 0) begin
      step(1'b0, 1'b0, sel, op, a, b, wa, wr, base_exp(1'b0, sel, op, a, b, wa, wr));
    end else begin
      step(1'b1, flush_at == 0, sel, op, a, b, wa, wr, e);
    end
  endtask

  task automatic nops(input int cnt);
    for (int i = 0; i < cnt; i++) issue(SEL_NOP, OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0, -1, -1);
  endtask

  // Monitor: compare DUT outputs with the oldest expectation, away from the clock edge
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      mon_cyc++;
      n_checks += 3;
      if ({wreg_o, waddr_o, wdata_o} !== {e.wreg, e.waddr, e.wdata}) begin
        n_fail++;
        $display("FAIL fwd cycle %0d: got wreg=%b waddr=%0d wdata=%h, expected wreg=%b waddr=%0d wdata=%h",
                 mon_cyc, wreg_o, waddr_o, wdata_o, e.wreg, e.waddr, e.wdata);
      end
      if (stallreq_o !== e.stall) begin
        n_fail++;
        $display("FAIL stallreq cycle %0d: got %b expected %b", mon_cyc, stallreq_o, e.stall);
      end
      if ({whilo_o, hi_o, lo_o} !== {e.whilo, e.hi, e.lo}) begin
        n_fail++;
        $display("FAIL hilo cycle %0d: got whilo=%b hi=%h lo=%h, expected whilo=%b hi=%h lo=%h",
                 mon_cyc, whilo_o, hi_o, lo_o, e.whilo, e.hi, e.lo);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0]  sels[5];
    logic [7:0]  ops[8];
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  op;
    sels = '{SEL_NOP, SEL_LOGIC, SEL_SHIFT, SEL_ARITH, 3'b111};
    ops  = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_NOP};

    rst = 1'b1; flush_i = 1'b0; alusel_i = SEL_NOP; aluop_i = OP_NOP;
    reg1_data_i = '0; reg2_data_i = '0; waddr_i = '0; wreg_i = 1'b0;
    #2 rst = 1'b0;

    // Outputs are all zero while reset is held, even with a live instruction present
    step(1'b0, 1'b0, SEL_LOGIC, OP_OR, 32'h1234_5678, 32'h1, 5'd7, 1'b1, '0);
    step(1'b0, 1'b0, SEL_ARITH, OP_DIVU, 32'd100, 32'd7, 5'd0, 1'b0, '0);

    issue(SEL_LOGIC, OP_OR,  32'h0000_FF00, 32'h0F0F_0000, 5'd9,  1'b1, -1, -1);
    issue(SEL_SHIFT, OP_SRA, 32'h8000_0000, 32'h0000_0024, 5'd10, 1'b1, -1, -1);
    issue(SEL_SHIFT, OP_SLL, 32'h0000_0001, 32'h0000_001F, 5'd31, 1'b1, -1, -1);
    issue(SEL_LOGIC, OP_NOR, 32'hF0F0_0000, 32'h000F_000F, 5'd1,  1'b1, -1, -1);

    issue(SEL_ARITH, OP_DIVU, 32'd100, 32'd7, 5'd0, 1'b0, -1, -1);
    issue(SEL_ARITH, OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b0, -1, -1);
    issue(SEL_ARITH, OP_DIV, 32'hFFFF_FFF9, 32'd0, 5'd0, 1'b0, -1, -1);
    issue(SEL_ARITH, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b0, -1, -1);
    issue(SEL_ARITH, OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0, -1, -1);

    // Flush in ON, ZERO, IDLE; then flush coinciding with END
    issue(SEL_ARITH, OP_DIV, 32'd1000, 32'd3, 5'd0, 1'b0, 10, -1);
    nops(3);
    issue(SEL_ARITH, OP_DIV, 32'd5, 32'd0, 5'd0, 1'b0, 1, -1);
    nops(1);
    issue(SEL_ARITH, OP_DIVU, 32'd5, 32'd2, 5'd0, 1'b0, 0, -1);
    nops(1);
    issue(SEL_ARITH, OP_DIV, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 5'd0, 1'b0, 33, -1);
    nops(1);

    // Asynchronous reset mid-divide, held one more cycle with a logic op present
    issue(SEL_ARITH, OP_DIV, 32'd12345, 32'd17, 5'd0, 1'b0, -1, 20);
    step(1'b0, 1'b0, SEL_LOGIC, OP_OR, 32'hA5A5_0000, 32'h0000_5A5A, 5'd3, 1'b1, '0);
    nops(3);

    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 9) < 3) begin
        op = ($urandom_range(0, 1) == 1) ? OP_DIV : OP_DIVU;
        case ($urandom_range(0, 4))
          0: b = 32'h0;
          1: b = 32'($urandom_range(1, 15));
          2: b = 32'(-$urandom_range(1, 15));
          3: a = 32'($urandom_range(0, 200));
          default: ;
        endcase
        issue(SEL_ARITH, op, a, b, 5'd0, 1'b0, -1, -1);
      end else begin
        issue(sels[$urandom_range(0, 4)], ops[$urandom_range(0, 7)], a, b,
              5'($urandom), 1'($urandom), -1, -1);
      end
    end

    nops(2);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
